// File: rtl/note_fall_engine_if.sv
// Spawn/hit/miss/readout bundle between the note engine and its neighbours.
// Master drives requests and the readout index; slave (the engine) answers.
interface note_fall_engine_if #(
  parameter int Y_W = 9
);
  logic           spawn_valid;
  logic [1:0]     spawn_lane;
  logic           spawn_ready;
  logic           hit_req;
  logic [1:0]     hit_lane;
  logic           hit_ok;
  logic           hit_bad;
  logic           miss_pulse;
  logic [7:0]     miss_count;
  logic [3:0]     rd_slot;
  logic           rd_active;
  logic [1:0]     rd_lane;
  logic [Y_W-1:0] rd_y;

  modport master (
    output spawn_valid, spawn_lane, hit_req, hit_lane, rd_slot,
    input  spawn_ready, hit_ok, hit_bad, miss_pulse, miss_count,
           rd_active, rd_lane, rd_y
  );

  modport slave (
    input  spawn_valid, spawn_lane, hit_req, hit_lane, rd_slot,
    output spawn_ready, hit_ok, hit_bad, miss_pulse, miss_count,
           rd_active, rd_lane, rd_y
  );
endinterface

// File: rtl/note_fall_engine.sv
// Falling-note slot engine: advance on frame_tick, judge hits, retire misses (NOTE_SPEED_SYNC_EN adds a speed synchronizer).
// Latency: hit_ok/hit_bad/miss_pulse one cycle after the request/tick; readout is combinational.
// Backpressure: spawn_ready drops when every slot is active; spawn_valid without it is ignored.
module note_fall_engine #(
  parameter int NUM_SLOTS = 8,
  parameter int Y_W       = 9,
  parameter int Y_MAX     = 479,
  parameter int STEP      = 2,
  parameter int HIT_LINE  = 440,
  parameter int HIT_WIN   = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                frame_tick,
  input  logic [1:0]          note_speed,
  note_fall_engine_if.slave   bus
);
  localparam int CW = Y_W + 2;
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CW-1:0] WIN_LO = CW'((HIT_LINE > HIT_WIN) ? (HIT_LINE - HIT_WIN) : 0);
  localparam logic [CW-1:0] WIN_HI = CW'(HIT_LINE + HIT_WIN);
  localparam logic [CW-1:0] YMAX_C = CW'(Y_MAX);

  logic [NUM_SLOTS-1:0] active_q;
  logic [1:0]           lane_q [NUM_SLOTS];
  logic [Y_W-1:0]       y_q    [NUM_SLOTS];
  logic                 hit_ok_q, hit_bad_q, miss_q;
  logic [7:0]           miss_cnt_q;

  logic [1:0]           spd_raw, spd_eff;
  logic [CW-1:0]        inc;
  logic [CW-1:0]        y_nx   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] cand, hit_clr, retire;
  logic                 hit_any, spawn_acc;
  logic [IW-1:0]        hit_idx, free_idx;
  logic [4:0]           miss_n;
  logic [8:0]           miss_sum;

`ifdef NOTE_SPEED_SYNC_EN
  logic [1:0] spd_s1, spd_s2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spd_s1 <= 2'd1;
      spd_s2 <= 2'd1;
    end else begin
      spd_s1 <= note_speed;
      spd_s2 <= spd_s1;
    end
  end

  assign spd_raw = spd_s2;
`else
  assign spd_raw = note_speed;
`endif

  assign spd_eff   = (spd_raw == 2'd0) ? 2'd1 : spd_raw;
  assign inc       = CW'(spd_eff) * CW'(STEP);
  assign spawn_acc = bus.spawn_valid && bus.spawn_ready;
  assign miss_sum  = {1'b0, miss_cnt_q} + 9'(miss_n);

  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    miss_n   = '0;
    cand     = '0;
    hit_clr  = '0;
    retire   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      y_nx[i] = {2'b00, y_q[i]} + inc;
      cand[i] = active_q[i] && (lane_q[i] == bus.hit_lane) &&
                ({2'b00, y_q[i]} >= WIN_LO) && ({2'b00, y_q[i]} <= WIN_HI);
    end
    // Descending scan so the lowest index wins both priority searches.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
      if (!active_q[i]) free_idx = IW'(i);
    end
    // A slot taken by a hit is never also counted as a miss.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_clr[i] = bus.hit_req && hit_any && (hit_idx == IW'(i));
      retire[i]  = frame_tick && active_q[i] && !hit_clr[i] && (y_nx[i] > YMAX_C);
      if (retire[i]) miss_n = miss_n + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_q   <= '0;
      hit_ok_q   <= 1'b0;
      hit_bad_q  <= 1'b0;
      miss_q     <= 1'b0;
      miss_cnt_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        lane_q[i] <= '0;
        y_q[i]    <= '0;
      end
    end else begin
      hit_ok_q   <= bus.hit_req && hit_any;
      hit_bad_q  <= bus.hit_req && !hit_any;
      miss_q     <= |retire;
      miss_cnt_q <= (miss_sum > 9'd255) ? 8'hFF : miss_sum[7:0];
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (hit_clr[i] || retire[i]) begin
          active_q[i] <= 1'b0;
          lane_q[i]   <= '0;
          y_q[i]      <= '0;
        end else if (frame_tick && active_q[i]) begin
          y_q[i] <= y_nx[i][Y_W-1:0];
        end else if (spawn_acc && (free_idx == IW'(i))) begin
          active_q[i] <= 1'b1;
          lane_q[i]   <= bus.spawn_lane;
          y_q[i]      <= '0;
        end
      end
    end
  end

  assign bus.spawn_ready = |(~active_q);
  assign bus.hit_ok      = hit_ok_q;
  assign bus.hit_bad     = hit_bad_q;
  assign bus.miss_pulse  = miss_q;
  assign bus.miss_count  = miss_cnt_q;

  always_comb begin
    bus.rd_active = 1'b0;
    bus.rd_lane   = '0;
    bus.rd_y      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (bus.rd_slot == 4'(i)) begin
        bus.rd_active = active_q[i];
        bus.rd_lane   = lane_q[i];
        bus.rd_y      = y_q[i];
      end
    end
  end
endmodule

// File: tb/tb_note_fall_engine.sv
// Directed bench for note_fall_engine: default instance plus a HIT_WIN=40 twin sharing all stimulus.
module tb_note_fall_engine;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] note_speed = 2'd1;
  int         tests = 0;
  int         fails = 0;

  note_fall_engine_if #(.Y_W(9)) b0 ();
  note_fall_engine_if #(.Y_W(9)) b1 ();

  assign b1.spawn_valid = b0.spawn_valid;
  assign b1.spawn_lane  = b0.spawn_lane;
  assign b1.hit_req     = b0.hit_req;
  assign b1.hit_lane    = b0.hit_lane;
  assign b1.rd_slot     = b0.rd_slot;

  note_fall_engine u0 (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .note_speed(note_speed), .bus(b0)
  );

  note_fall_engine #(.HIT_WIN(40)) u1 (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .note_speed(note_speed), .bus(b1)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) cyc();
    frame_tick = 1'b0;
  endtask

  task automatic spawn(input logic [1:0] l);
    b0.spawn_valid = 1'b1;
    b0.spawn_lane  = l;
    cyc();
    b0.spawn_valid = 1'b0;
  endtask

  task automatic hit(input logic [1:0] l);
    b0.hit_req  = 1'b1;
    b0.hit_lane = l;
    cyc();
    b0.hit_req  = 1'b0;
  endtask

  task automatic slot(input string tag, input int s, input logic act,
                      input logic [1:0] ln, input logic [8:0] yy);
    b0.rd_slot = 4'(s);
    #1;
    chk({tag, "_act"},  32'(b0.rd_active), 32'(act));
    chk({tag, "_lane"}, 32'(b0.rd_lane),   32'(ln));
    chk({tag, "_y"},    32'(b0.rd_y),      32'(yy));
  endtask

  task automatic do_reset();
    cyc();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    b0.spawn_valid = 1'b0;
    b0.spawn_lane  = 2'd0;
    b0.hit_req     = 1'b0;
    b0.hit_lane    = 2'd0;
    b0.rd_slot     = 4'd0;

    // Reset state
    repeat (2) cyc();
    chk("rst_ready", 32'(b0.spawn_ready), 32'd1);
    chk("rst_hitok", 32'(b0.hit_ok), 32'd0);
    chk("rst_hitbad", 32'(b0.hit_bad), 32'd0);
    chk("rst_miss", 32'(b0.miss_pulse), 32'd0);
    chk("rst_mcnt", 32'(b0.miss_count), 32'd0);
    slot("rst_s0", 0, 1'b0, 2'd0, 9'd0);
    resetn = 1'b1;

    // One note, 1x, 10 frames -> y=20; one more frame at code 0 (1x) -> 22
    cyc();
    note_speed = 2'd1;
    spawn(2'd2);
    slot("sp_s0", 0, 1'b1, 2'd2, 9'd0);
    for (int k = 0; k < 10; k++) begin
      ticks(1);
      cyc();
    end
    slot("t10", 0, 1'b1, 2'd2, 9'd20);
    chk("t10_ready", 32'(b0.spawn_ready), 32'd1);
    note_speed = 2'd0;
    ticks(1);
    slot("spd0", 0, 1'b1, 2'd2, 9'd22);

    // Fill all slots, then an ignored 9th request
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fill_rdy%0d", i), 32'(b0.spawn_ready), 32'd1);
      b0.spawn_valid = 1'b1;
      b0.spawn_lane  = 2'(i % 4);
      cyc();
    end
    chk("full_ready", 32'(b0.spawn_ready), 32'd0);
    b0.spawn_lane = 2'd1;
    cyc();
    b0.spawn_valid = 1'b0;
    chk("full9_ready", 32'(b0.spawn_ready), 32'd0);
    slot("full_s0", 0, 1'b1, 2'd0, 9'd0);
    slot("full_s3", 3, 1'b1, 2'd3, 9'd0);
    slot("full_s7", 7, 1'b1, 2'd3, 9'd0);
    slot("oob8", 8, 1'b0, 2'd0, 9'd0);
    slot("oob15", 15, 1'b0, 2'd0, 9'd0);

    // 3x fall to retirement: 6 rows/frame, last visible 474
    do_reset();
    note_speed = 2'd3;
    spawn(2'd0);
    ticks(1);
    slot("f3_1", 0, 1'b1, 2'd0, 9'd6);
    ticks(1);
    slot("f3_2", 0, 1'b1, 2'd0, 9'd12);
    ticks(77);
    slot("f3_79", 0, 1'b1, 2'd0, 9'd474);
    chk("f3_79_miss", 32'(b0.miss_pulse), 32'd0);
    ticks(1);
    chk("f3_ret_miss", 32'(b0.miss_pulse), 32'd1);
    chk("f3_ret_mcnt", 32'(b0.miss_count), 32'd1);
    slot("f3_ret", 0, 1'b0, 2'd0, 9'd0);
    spawn(2'd2);
    chk("f3_miss_drop", 32'(b0.miss_pulse), 32'd0);
    slot("f3_reuse", 0, 1'b1, 2'd2, 9'd0);

    // Hit judgement around the 424..456 window
    do_reset();
    note_speed = 2'd3;
    spawn(2'd1);
    ticks(70);
    slot("h420", 0, 1'b1, 2'd1, 9'd420);
    hit(2'd1);
    chk("h420_bad", 32'(b0.hit_bad), 32'd1);
    chk("h420_ok", 32'(b0.hit_ok), 32'd0);
    slot("h420_keep", 0, 1'b1, 2'd1, 9'd420);
    note_speed = 2'd1;
    ticks(5);
    chk("h_bad_drop", 32'(b0.hit_bad), 32'd0);
    slot("h430", 0, 1'b1, 2'd1, 9'd430);
    hit(2'd0);
    chk("hl0_bad", 32'(b0.hit_bad), 32'd1);
    chk("hl0_ok", 32'(b0.hit_ok), 32'd0);
    slot("hl0_keep", 0, 1'b1, 2'd1, 9'd430);
    hit(2'd1);
    chk("hl1_ok", 32'(b0.hit_ok), 32'd1);
    chk("hl1_bad", 32'(b0.hit_bad), 32'd0);
    slot("hl1_clr", 0, 1'b0, 2'd0, 9'd0);
    cyc();
    chk("hl1_ok_drop", 32'(b0.hit_ok), 32'd0);
    note_speed = 2'd3;
    spawn(2'd3);
    ticks(76);
    slot("h456", 0, 1'b1, 2'd3, 9'd456);
    hit(2'd3);
    chk("h456_ok", 32'(b0.hit_ok), 32'd1);
    chk("h456_mcnt", 32'(b0.miss_count), 32'd0);

    // Hit and frame in the same cycle at y=474
    do_reset();
    note_speed = 2'd3;
    spawn(2'd0);
    ticks(79);
    slot("c474", 0, 1'b1, 2'd0, 9'd474);
    frame_tick     = 1'b1;
    b0.hit_req     = 1'b1;
    b0.hit_lane    = 2'd0;
    cyc();
    frame_tick     = 1'b0;
    b0.hit_req     = 1'b0;
    chk("c_w16_bad", 32'(b0.hit_bad), 32'd1);
    chk("c_w16_ok", 32'(b0.hit_ok), 32'd0);
    chk("c_w16_miss", 32'(b0.miss_pulse), 32'd1);
    chk("c_w16_mcnt", 32'(b0.miss_count), 32'd1);
    chk("c_w40_ok", 32'(b1.hit_ok), 32'd1);
    chk("c_w40_bad", 32'(b1.hit_bad), 32'd0);
    chk("c_w40_miss", 32'(b1.miss_pulse), 32'd0);
    chk("c_w40_mcnt", 32'(b1.miss_count), 32'd0);
    slot("c_w16_s0", 0, 1'b0, 2'd0, 9'd0);
    chk("c_w40_s0", 32'(b1.rd_active), 32'd0);

    // Spawn during a frame tick, then reset mid-sequence
    note_speed = 2'd2;
    spawn(2'd0);
    ticks(25);
    slot("sf100", 0, 1'b1, 2'd0, 9'd100);
    b0.spawn_valid = 1'b1;
    b0.spawn_lane  = 2'd1;
    frame_tick     = 1'b1;
    cyc();
    b0.spawn_valid = 1'b0;
    frame_tick     = 1'b0;
    slot("sf_old", 0, 1'b1, 2'd0, 9'd104);
    slot("sf_new", 1, 1'b1, 2'd1, 9'd0);
    chk("sf_mcnt", 32'(b0.miss_count), 32'd1);
    b0.hit_req  = 1'b1;
    b0.hit_lane = 2'd1;
    #2;
    resetn = 1'b0;
    #1;
    slot("mr_s0", 0, 1'b0, 2'd0, 9'd0);
    slot("mr_s1", 1, 1'b0, 2'd0, 9'd0);
    chk("mr_mcnt", 32'(b0.miss_count), 32'd0);
    chk("mr_ready", 32'(b0.spawn_ready), 32'd1);
    cyc();
    chk("mr_nobad", 32'(b0.hit_bad), 32'd0);
    chk("mr_nook", 32'(b0.hit_ok), 32'd0);
    b0.hit_req = 1'b0;
    resetn = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/note_fall_engine.md
Name: note_fall_engine

Overview:
- Note-slot engine for the rhythm game. Holds up to NUM_SLOTS falling notes, each with a lane and a vertical position.
- Advances every active note once per frame_tick by a distance scaled by the 1x/2x/3x note_speed code coming from the speed switch decoder.
- Sits downstream of the speed decoder, and upstream of the VGA note renderer and the score/HEX logic.
- Also judges player hits and reports misses.

Parameters:
- NUM_SLOTS, 8, number of concurrent note slots (2..16).
- Y_W, 9, position width in bits.
- Y_MAX, 479, last visible row; a note whose next position would exceed this is retired as a miss.
- STEP, 2, rows moved per frame at 1x speed.
- HIT_LINE, 440, row of the judgement line.
- HIT_WIN, 16, half-width of the hit window in rows.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- note_speed  in  2  1=1x, 2=2x, 3=3x; value 0 is treated as 1x
- spawn_valid  in  1  request to launch a note
- spawn_lane  in  2  lane of the requested note
- spawn_ready  out  1  at least one slot is free
- hit_req  in  1  one-cycle player key press
- hit_lane  in  2  lane pressed
- hit_ok  out  1  pulse: a note was hit
- hit_bad  out  1  pulse: key press matched no note
- miss_pulse  out  1  pulse: one or more notes fell off screen this frame
- miss_count  out  8  saturating count of missed notes
- rd_slot  in  4  slot index for the renderer
- rd_active  out  1  selected slot is active
- rd_lane  out  2  selected slot's lane
- rd_y  out  Y_W  selected slot's position

Behaviour:
- Reset (async, resetn=0):
  - All slots inactive, y=0, lane=0.
  - hit_ok, hit_bad, miss_pulse = 0; miss_count = 0; spawn_ready = 1.
- Speed sampling:
  - The effective speed code is taken in the same cycle as frame_tick.
  - Increment per frame = spd*STEP, with spd in {1,2,3}.
  - Computed in Y_W+2 bits; no wrap-around is permitted.
- Frame update, on frame_tick, for each active slot:
  - Form y_next = y + inc.
  - If y_next > Y_MAX: clear the slot and count it as a miss.
  - Otherwise: y <= y_next.
- Miss reporting:
  - miss_pulse is asserted for one cycle, one cycle after a frame_tick that retired at least one note.
  - miss_count adds the number of notes retired that frame and saturates at 255.
- Spawn:
  - spawn_ready = OR of the inactive flags, taken from registered state.
  - Acceptance = spawn_valid && spawn_ready.
  - On acceptance, the lowest-index free slot becomes active with y=0 and lane=spawn_lane.
  - A note spawned in the same cycle as frame_tick is not advanced on that tick.
  - A slot freed in cycle N (by miss or hit) is spawnable from cycle N+1.
- Hit judgement, on hit_req:
  - Candidates: active slots with lane==hit_lane and |y - HIT_LINE| <= HIT_WIN.
  - The comparison uses the pre-update y.
  - If any candidate exists: clear the lowest-index candidate and pulse hit_ok one cycle later.
  - If no candidate exists: pulse hit_bad one cycle later.
  - At most one note is removed per hit_req.
- Simultaneous hit_req and frame_tick:
  - The hit is judged on pre-update positions.
  - The hit slot is cleared and is not counted as a miss, even if it would also have been retired.
  - All other slots update normally.
- Readout port:
  - Combinational from the slot registers.
  - rd_slot >= NUM_SLOTS returns rd_active=0, rd_lane=0, rd_y=0.
- Reset asserted mid-frame or mid-hit: all state is cleared immediately and no pending pulses are emitted.

Optional Feature:
- Macro: NOTE_SPEED_SYNC_EN.
- Defined: note_speed passes through a 2-flop synchronizer clocked by clk and reset to 2'd1. The frame update uses the synchronized value, so a switch change becomes effective at the first frame_tick at least 2 cycles after the change.
- Not defined: note_speed is used directly at frame_tick.

Test Plan:
- Reset, then 1 spawn in lane 2, speed=1, 10 frame_ticks -> rd_y=20, rd_lane=2, rd_active=1, spawn_ready=1.
- Spawn 8 notes back-to-back -> slots 0..7 fill in order; spawn_ready=0 after the 8th; a 9th spawn_valid is ignored with no state change.
- speed=3, one note, ticks until retirement -> y goes 0, 6, 12, …, 474; the next tick retires it; miss_pulse one cycle later; miss_count=1; slot reusable the following cycle.
- Note at y=430 in lane 1:
  - hit_req lane 1 -> hit_ok pulse, slot cleared.
  - hit_req lane 0 -> hit_bad pulse, note untouched.
  - hit_req lane 1 with the note at y=420 -> hit_bad.
- Note at y=474 (speed 3), with hit_req and frame_tick in the same cycle -> hit_bad (474 is outside the window 424..456); miss_pulse follows. Repeat with HIT_WIN=40 -> hit_ok, no miss, miss_count unchanged.
- Spawn and frame_tick in the same cycle with an existing note at y=100, speed 2 -> existing note goes to y=104, new note stays at y=0; assert resetn=0 mid-sequence -> all rd_active=0 and miss_count=0 immediately.
